// File: rtl/ysyx_23060240_ifu_pkg.sv
// ysyx_23060240_ifu_pkg: shared fetch-path types, response codes and pmem window.
package ysyx_23060240_ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } ifu_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
   localparam logic [31:0] PMEM_SIZE = 32'h0800_0000;

   // 33-bit window bound so a window ending at 2^32 never wraps
   function automatic logic [1:0] resp_code(input logic [31:0] addr, input logic [31:0] base,
                                            input logic [31:0] size);
      logic [32:0] lim;
      lim = {1'b0, base} + {1'b0, size};
      return (addr[1:0] != 2'b00) ? RESP_SLVERR :
             ({1'b0, addr} < {1'b0, base} || {1'b0, addr} >= lim) ? RESP_DECERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/ysyx_23060240_ifu_sram_if.sv
// ysyx_23060240_ifu_sram_if: fetch read-address/read-data bus plus the pmem read port.
interface ysyx_23060240_ifu_sram_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        pmem_en;
   logic [31:0] pmem_addr;
   logic [31:0] pmem_rdata;

   modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
   modport slave (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
   modport mem_client (output pmem_en, pmem_addr, input pmem_rdata);
   modport mem_model (input pmem_en, pmem_addr, output pmem_rdata);
endinterface

// File: rtl/ysyx_23060240_pmem_rport.sv
// ysyx_23060240_pmem_rport: one pmem read per enable pulse, word registered on that edge.
// The memory answers combinationally within the cycle, so a real SRAM macro can replace it.
module ysyx_23060240_pmem_rport (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clr,
   input  logic [31:0] addr,
   ysyx_23060240_ifu_sram_if.mem_client mem,
   output logic [31:0] word
);

   assign mem.pmem_en   = en;
   assign mem.pmem_addr = addr;

   always_ff @(posedge clk or negedge rst)
      if (!rst) word <= '0;
      else if (en) word <= mem.pmem_rdata;
      else if (clr) word <= '0;

endmodule

// File: rtl/ysyx_23060240_ifu_sram.sv
// ysyx_23060240_ifu_sram: instruction-memory slave with programmable read latency.
// rvalid rises LAT edges after the accepting edge; the RESP-entry edge does the pmem read.
module ysyx_23060240_ifu_sram
   import ysyx_23060240_ifu_pkg::*;
#(
   parameter int unsigned  LAT  = 1,
   parameter logic [31:0] BASE = PMEM_BASE,
   parameter logic [31:0] SIZE = PMEM_SIZE
) (
   input logic clk,
   input logic rst,
   ysyx_23060240_ifu_sram_if.slave      bus,
   ysyx_23060240_ifu_sram_if.mem_client mem
);

   if (LAT > 15) begin : g_bad_lat
      $error("ysyx_23060240_ifu_sram: LAT must be in 0..15");
   end

   ifu_state_t  state, state_nxt;
   logic [3:0]  cnt;
   logic [31:0] addr;
   logic [31:0] req_addr;
   logic [1:0]  code;
   logic [1:0]  rresp_q;
   logic        arready_q;
   logic        rvalid_q;
   logic        accept;
   logic        enter;
   logic        done;

   assign accept   = bus.arvalid && arready_q;
   assign done     = rvalid_q && bus.rready;
   assign enter    = (accept && LAT == 0) || (state == WAIT && cnt == 4'd1);
   // with no wait cycles the response is formed from the address being accepted
   assign req_addr = (LAT == 0) ? bus.araddr : addr;
   assign code     = resp_code(req_addr, BASE, SIZE);

   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rresp   = rresp_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? ((LAT == 0) ? RESP : WAIT) : IDLE;
         WAIT:    state_nxt = (cnt == 4'd1) ? RESP : WAIT;
         RESP:    state_nxt = done ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         addr      <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
      end else begin
         state     <= state_nxt;
         arready_q <= state_nxt == IDLE;
         if (accept) begin
            addr <= bus.araddr;
            cnt  <= 4'(LAT);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter) begin
            rvalid_q <= 1'b1;
            rresp_q  <= code;
         end else if (done) begin
            rvalid_q <= 1'b0;
         end
      end

   ysyx_23060240_pmem_rport u_rport (
      .clk  (clk),
      .rst  (rst),
      .en   (enter && code == RESP_OKAY),
      .clr  (enter && code != RESP_OKAY),
      .addr (req_addr),
      .mem  (mem),
      .word (bus.rdata)
   );

endmodule

// File: tb/tb_ysyx_23060240_ifu_sram.sv
// tb_ysyx_23060240_ifu_sram: five DUT configurations sharing one master; sel picks the active one.
module tb_ysyx_23060240_ifu_sram;

   localparam int N = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          sel = 0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        rready = 1'b0;
   logic        arready_a [N];
   logic        rvalid_a [N];
   logic        pen_a [N];
   logic [31:0] rdata_a [N];
   logic [1:0]  rresp_a [N];
   logic        arready, rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   int          tests = 0;
   int          fails = 0;
   int          calls = 0;

   always #5 clk = ~clk;

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : (g == 3) ? 2 : 1;
   endfunction

   function automatic logic [31:0] base_of(input int g);
      return (g == 4) ? 32'hFFFF_F000 : 32'h8000_0000;
   endfunction

   function automatic logic [31:0] size_of(input int g);
      return (g == 4) ? 32'h0000_1000 : 32'h0800_0000;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] s);
      if (a % 4 != 0) return 2'b10;
      if (longint'(a) < longint'(b) || longint'(a) >= longint'(b) + longint'(s)) return 2'b11;
      return 2'b00;
   endfunction

   for (genvar g = 0; g < N; g++) begin : u
      ysyx_23060240_ifu_sram_if bus ();
      assign bus.araddr     = araddr;
      assign bus.arvalid    = arvalid && sel == g;
      assign bus.rready     = rready;
      assign bus.pmem_rdata = mem_word(bus.pmem_addr);
      assign arready_a[g]   = bus.arready;
      assign rvalid_a[g]    = bus.rvalid;
      assign pen_a[g]       = bus.pmem_en;
      assign rdata_a[g]     = bus.rdata;
      assign rresp_a[g]     = bus.rresp;
      ysyx_23060240_ifu_sram #(.LAT(lat_of(g)), .BASE(base_of(g)), .SIZE(size_of(g))) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus),
         .mem (bus)
      );
   end

   assign arready = arready_a[sel];
   assign rvalid  = rvalid_a[sel];
   assign rdata   = rdata_a[sel];
   assign rresp   = rresp_a[sel];

   always @(posedge clk) if (rst && pen_a[sel]) calls++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one complete transaction from a negedge in IDLE, ending on the negedge after the handshake
   task automatic fetch(input logic [31:0] a, input int stall, input string tag);
      logic [1:0]  er;
      logic [31:0] ed;
      int          n, c0;
      er = exp_resp(a, base_of(sel), size_of(sel));
      ed = (er == 2'b00) ? mem_word(a) : 32'h0;
      c0 = calls;
      chk({tag, " arready idle"}, 32'(arready), 1);
      araddr  = a;
      arvalid = 1'b1;
      rready  = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      araddr  = $urandom;
      n = 0;
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, n, lat_of(sel));
      chk({tag, " rresp"}, 32'(rresp), 32'(er));
      chk({tag, " rdata"}, rdata, ed);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, " hold rvalid"}, 32'(rvalid), 1);
         chk({tag, " hold rdata"}, rdata, ed);
         chk({tag, " hold rresp"}, 32'(rresp), 32'(er));
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk({tag, " rvalid drop"}, 32'(rvalid), 0);
      chk({tag, " arready back"}, 32'(arready), 1);
      chk({tag, " pmem calls"}, calls - c0, (er == 2'b00) ? 1 : 0);
   endtask

   initial begin
      logic [31:0] pc, a, exp_a;
      logic [31:0] q [$];
      int          last, got, nacc, c0;
      #2 rst = 1'b0;
      #1;
      chk("async reset rvalid", 32'(rvalid), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset arready", 32'(arready), 0);
         chk("reset rvalid", 32'(rvalid), 0);
         chk("reset rdata", rdata, 0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 chk("arready after release", 32'(arready), 1);
      @(negedge clk);

      sel = 0;
      fetch(32'h8000_0000, 0, "basic");
      fetch(32'h8000_0002, 0, "misaligned");
      fetch(32'h7FFF_FFFC, 0, "below base");
      fetch(32'h8800_0000, 0, "at limit");
      fetch(32'h87FF_FFFC, 1, "last word");

      sel = 1;
      fetch(32'h8000_0004, 5, "backpressure");

      sel = 4;
      fetch(32'hFFFF_FFFC, 0, "top no wrap");
      fetch(32'hFFFF_EFFC, 0, "top below");

      sel = 2;
      araddr  = 32'h8000_0008;
      arvalid = 1'b1;
      c0 = calls;
      @(negedge clk);
      arvalid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid reset rvalid", 32'(rvalid), 0);
      chk("mid reset arready", 32'(arready), 0);
      chk("mid reset rdata", rdata, 0);
      repeat (4) @(negedge clk);
      chk("mid reset rvalid held", 32'(rvalid), 0);
      chk("mid reset no pmem", calls - c0, 0);
      rst = 1'b1;
      @(negedge clk);
      fetch(32'h8000_0008, 0, "after reset");

      for (int i = 0; i < 12; i++) begin
         sel = $urandom_range(0, 3);
         case ($urandom_range(0, 2))
            0:       a = 32'h8000_0000 + ($urandom_range(0, 32'h1FF_FFFF) << 2);
            1:       a = 32'h8000_0000 + $urandom_range(0, 4095) | 32'h1;
            default: a = $urandom;
         endcase
         fetch(a, $urandom_range(0, 3), "random");
      end

      sel = 3;
      pc = 32'h8000_0000;
      araddr = pc;
      arvalid = 1'b1;
      rready = 1'b1;
      last = -1;
      got = 0;
      nacc = 0;
      c0 = calls;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         logic acc;
         acc = arready && arvalid;
         if (rvalid) begin
            exp_a = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
            chk("stream word", rdata, mem_word(exp_a));
            got++;
         end
         if (acc) begin
            if (last >= 0) chk("stream spacing", cyc - last, 4);
            last = cyc;
            q.push_back(araddr);
            nacc++;
         end
         @(negedge clk);
         if (acc) begin
            pc += 4;
            araddr = pc;
            arvalid = nacc < 8;
         end
      end
      arvalid = 1'b0;
      rready = 1'b0;
      chk("stream responses", got, 8);
      chk("stream pmem calls", calls - c0, 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
